// File: rtl/encoder_step_timer_pkg.sv
// Shared types for the encoder step timer: FSM states, the period sample
// record and the default period width.
package encoder_step_timer_pkg;

  localparam int PERW_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } state_t;

  typedef struct packed {
    logic [PERW_DEFAULT-1:0] period;
    logic                    dir;
  } step_sample_t;

endpackage

// File: rtl/sample_skid1.sv
// Generic one-entry valid/ready holding register. A sample offered while the
// entry is full and not being drained is discarded and flagged sticky.
module sample_skid1 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         dropped
);

  logic can_load;

  // The entry accepts a new sample when it is empty or drains this cycle.
  assign can_load = !out_valid || out_ready;

  // NOTE: the data register is a single word, so it is reset along with
  // valid; a deep storage array would be left unreset instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      dropped   <= 1'b0;
    end else if (load_valid) begin
      if (can_load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
      end else begin
        dropped <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/encoder_step_timer.sv
// Times successive same-direction encoder steps, emits each period through a
// one-entry valid/ready buffer, and flags a stall when steps stop arriving.
module encoder_step_timer
  import encoder_step_timer_pkg::*;
#(
  parameter int              PERW    = PERW_DEFAULT,
  parameter logic [PERW-1:0] TIMEOUT = PERW'(5_000_000)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trvl,
  input  logic            fwd_bck,
  output logic [PERW-1:0] period,
  output logic            period_dir,
  output logic            period_valid,
  input  logic            period_ready,
  output logic            stalled,
  output logic            dropped
);

  state_t          state;
  logic [PERW-1:0] cnt;
  logic            last_dir;
  logic            sample_valid;

  // A period closes only on a step in the same direction as the reference.
  assign sample_valid = (state == RUN) && trvl && (fwd_bck == last_dir);

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dir <= 1'b0;
      stalled  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trvl) begin
            cnt      <= PERW'(1);
            last_dir <= fwd_bck;
            state    <= RUN;
          end
        end
        RUN: begin
          // A step on the timeout cycle wins over declaring a stall.
          if (trvl) begin
            cnt      <= PERW'(1);
            last_dir <= fwd_bck;
          end else if (cnt == TIMEOUT) begin
            state   <= STALL;
            stalled <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STALL: begin
          if (trvl) begin
            stalled  <= 1'b0;
            cnt      <= PERW'(1);
            last_dir <= fwd_bck;
            state    <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [PERW:0] buf_data;

  sample_skid1 #(
    .W(PERW + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .load_valid(sample_valid),
    .load_data ({fwd_bck, cnt}),
    .out_ready (period_ready),
    .out_valid (period_valid),
    .out_data  (buf_data),
    .dropped   (dropped)
  );

  assign {period_dir, period} = buf_data;

endmodule

// File: tb/tb_encoder_step_timer.sv
// Self-checking bench for encoder_step_timer: expected samples are queued as
// steps are driven and compared when the output buffer transfers them.
module tb_encoder_step_timer;
  import encoder_step_timer_pkg::*;

  localparam int              PERW    = PERW_DEFAULT;
  localparam logic [PERW-1:0] TIMEOUT = PERW'(1000);

  logic            clk = 1'b0;
  logic            reset;
  logic            trvl;
  logic            fwd_bck;
  logic [PERW-1:0] period;
  logic            period_dir;
  logic            period_valid;
  logic            period_ready;
  logic            stalled;
  logic            dropped;

  int checks = 0;
  int errors = 0;
  step_sample_t exp_q[$];

  encoder_step_timer #(
    .PERW   (PERW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trvl        (trvl),
    .fwd_bck     (fwd_bck),
    .period      (period),
    .period_dir  (period_dir),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .stalled     (stalled),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every transfer the DUT makes must match the oldest queued sample.
  step_sample_t got;
  always @(negedge clk) begin
    if (reset && period_valid && period_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_sample", period_valid, 1'b0);
      end else begin
        got = exp_q.pop_front();
        check("period", period, got.period);
        check("period_dir", period_dir, got.dir);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input logic dir);
    trvl    = 1'b1;
    fwd_bck = dir;
    @(posedge clk);
    #1;
    trvl = 1'b0;
  endtask

  task automatic expect_sample(input int p, input logic d);
    step_sample_t s;
    s.period = PERW'(p);
    s.dir    = d;
    exp_q.push_back(s);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, period_valid, 1'b0);
    check({tag, "_period"}, period, 0);
    check({tag, "_dir"}, period_dir, 1'b0);
    check({tag, "_stalled"}, stalled, 1'b0);
    check({tag, "_dropped"}, dropped, 1'b0);
  endtask

  // Asserts reset between clock edges, checks outputs while held, then releases.
  task automatic do_reset();
    check("queue_empty_at_reset", exp_q.size(), 0);
    #2 reset = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk);
    #1 check_zero("held_reset");
    reset        = 1'b1;
    period_ready = 1'b1;
    cycles(1);
  endtask

  initial begin
    reset        = 1'b0;
    trvl         = 1'b0;
    fwd_bck      = 1'b0;
    period_ready = 1'b1;
    cycles(3);
    check_zero("power_on");
    reset = 1'b1;
    cycles(1);

    // Reset mid-run, then a single step must not produce a sample.
    step(1'b1);
    cycles(30);
    do_reset();
    step(1'b1);
    check("first_step_no_valid", period_valid, 1'b0);
    cycles(5);
    check("first_step_still_no_valid", period_valid, 1'b0);

    // Steady forward steps every 100 cycles.
    do_reset();
    step(1'b1);
    for (int k = 0; k < 4; k++) begin
      cycles(1);
      check("steady_valid_one_cycle", period_valid, 1'b0);
      cycles(98);
      expect_sample(100, 1'b1);
      step(1'b1);
      check("steady_valid_latency", period_valid, 1'b1);
    end
    cycles(2);

    // Reversal: fwd@0, fwd@50, bck@80, bck@200.
    do_reset();
    step(1'b1);
    cycles(49);
    expect_sample(50, 1'b1);
    step(1'b1);
    cycles(29);
    step(1'b0);
    check("reversal_no_sample", period_valid, 1'b0);
    cycles(119);
    expect_sample(120, 1'b0);
    step(1'b0);
    cycles(2);

    // Stall after TIMEOUT silent cycles, recovery without a sample.
    do_reset();
    step(1'b1);
    cycles(999);
    check("stall_not_yet", stalled, 1'b0);
    cycles(1);
    check("stall_set", stalled, 1'b1);
    cycles(499);
    step(1'b1);
    check("stall_cleared", stalled, 1'b0);
    check("stall_recovery_no_sample", period_valid, 1'b0);
    cycles(99);
    expect_sample(100, 1'b1);
    step(1'b1);
    cycles(2);

    // Step on exactly the timeout cycle is a normal period.
    do_reset();
    step(1'b1);
    cycles(999);
    expect_sample(1000, 1'b1);
    step(1'b1);
    check("edge_no_stall", stalled, 1'b0);
    check("edge_valid", period_valid, 1'b1);
    cycles(2);
    check("edge_still_no_stall", stalled, 1'b0);

    // Backpressure: first sample held, second dropped, third replaces on drain.
    do_reset();
    period_ready = 1'b0;
    step(1'b1);
    cycles(9);
    expect_sample(10, 1'b1);
    step(1'b1);
    check("bp_valid", period_valid, 1'b1);
    check("bp_period", period, 10);
    cycles(9);
    check("bp_period_stable", period, 10);
    check("bp_no_drop_yet", dropped, 1'b0);
    step(1'b1);
    check("bp_dropped", dropped, 1'b1);
    check("bp_period_kept", period, 10);
    check("bp_valid_kept", period_valid, 1'b1);
    cycles(4);
    expect_sample(5, 1'b1);
    trvl         = 1'b1;
    fwd_bck      = 1'b1;
    period_ready = 1'b1;
    @(posedge clk);
    #1;
    trvl = 1'b0;
    check("bp_reload_valid", period_valid, 1'b1);
    check("bp_reload_period", period, 5);
    cycles(1);
    check("bp_drained", period_valid, 1'b0);
    check("bp_dropped_sticky", dropped, 1'b1);

    // Steps on three consecutive cycles give two one-cycle periods.
    do_reset();
    expect_sample(1, 1'b1);
    expect_sample(1, 1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    cycles(3);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder_step_timer.md
# encoder_step_timer

Measures the time between successive fixed-distance travel steps produced by the quadrature encoder top level (its one-cycle travel pulse and forward/back flag). It emits each step-to-step period in clock cycles, together with direction, through a one-entry valid/ready output buffer. It also flags a stalled motor when no step arrives within a programmable timeout. It sits directly downstream of the encoder top level and feeds the speed-control logic.

## Interface
- `PERW`, 24: period counter and output width in bits.
- `TIMEOUT`, 24'd5_000_000: cycle count with no step after which the shaft is declared stalled. Range 2..2^PERW-1.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to `clk` upstream.
- `trvl`  in  1  one-cycle step pulse from the encoder top level.
- `fwd_bck`  in  1  direction of the step; sampled only when `trvl`=1 (1 = forward).
- `period`  out  PERW  cycles between the two most recent same-direction steps.
- `period_dir`  out  1  direction of the step that closed the period.
- `period_valid`  out  1  `period` and `period_dir` are valid.
- `period_ready`  in  1  the consumer accepts the sample.
- `stalled`  out  1  no step for `TIMEOUT` cycles.
- `dropped`  out  1  sticky flag: at least one sample was lost to backpressure.

## Operation
- States: IDLE (no reference step), RUN (timing since last step), STALL (timeout expired).
- Registers: `cnt` (PERW bits), `last_dir`, state, output buffer (`period`, `period_dir`, `period_valid`), `stalled`, `dropped`.
- IDLE:
  - On `trvl`: `cnt`<=1, `last_dir`<=`fwd_bck`, go to RUN.
  - No sample is emitted.
- RUN, each cycle without `trvl`:
  - If `cnt`==`TIMEOUT`: go to STALL and set `stalled`<=1.
  - Otherwise `cnt`<=`cnt`+1.
- RUN, on `trvl`:
  - If `fwd_bck`==`last_dir`: produce a sample with `period`=`cnt` and `period_dir`=`fwd_bck`.
  - On a direction reversal: produce no sample and set `last_dir`<=`fwd_bck`.
  - In both cases `cnt`<=1 and the block stays in RUN.
  - A step taken while `cnt`==`TIMEOUT` is a normal step and takes priority over the timeout.
- STALL:
  - `cnt` holds its value.
  - On `trvl`: `stalled`<=0, `cnt`<=1, `last_dir`<=`fwd_bck`, go to RUN. No sample is emitted, because the first step after a stall is only a new reference.
- Output buffer (valid/ready):
  - A transfer occurs in any cycle where `period_valid` and `period_ready` are both 1.
  - `period_valid` falls after a transfer unless a new sample loads in the same cycle. On a simultaneous transfer and new sample, the new sample loads and `period_valid` stays 1.
  - If a new sample arrives while `period_valid`=1 and `period_ready`=0: the buffered sample is kept, the new one is discarded, and `dropped`<=1.
  - `period` and `period_dir` are stable while `period_valid`=1 and `period_ready`=0.
- Reset, asynchronous and taking effect at any time:
  - State goes to IDLE.
  - `cnt`=0, `last_dir`=0.
  - `period`=0, `period_dir`=0, `period_valid`=0, `stalled`=0, `dropped`=0.
  - A sample pending at reset is lost.
- Arithmetic: `cnt` never exceeds `TIMEOUT`, so it cannot wrap. The minimum period is 1 (steps on consecutive cycles).

## Timing
- Steps at cycles t0 and t1 in the same direction give `period`=t1−t0.
- `period_valid` rises in cycle t1+1 (one-cycle latency).
- `stalled` rises in cycle t0+`TIMEOUT`+1 if no step occurs in cycles t0+1..t0+`TIMEOUT`.
- `stalled` falls in the cycle after the next step.
- `period_ready` is combinationally observed; there is no combinational path from any input to any output.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, STALL);
  - a `step_sample_t` struct {period, dir};
  - the default `PERW`.
- One sub-module, `sample_skid1`: a generic one-entry valid/ready holding register with a drop-on-full indication. It is reusable by other measurement blocks.

## Test plan
- **Reset and first step:** reset low mid-run, then one `trvl` pulse. Required: all outputs 0 throughout, and `period_valid` stays 0 after the first step.
- **Steady forward steps:** forward steps every 100 cycles with `period_ready`=1. Required: samples `period`=100, `period_dir`=1, each with `period_valid` high for exactly 1 cycle, 1 cycle after each step.
- **Reversal:** steps fwd@0, fwd@50, bck@80, bck@200. Required: exactly two samples, (50, fwd) and then (120, bck).
- **Stall:** `TIMEOUT`=1000, step@0, then silence.
  - Required: `stalled`=1 at cycle 1001.
  - Step@1500 clears `stalled` at cycle 1501 with no sample.
  - Next step@1600 gives `period`=100.
  - A separate case with a step at exactly cycle 1000 gives `period`=1000 and no stall.
- **Backpressure:** `period_ready`=0, steps every 10 cycles for 3 periods.
  - Required: the first sample (10) is held stable and `dropped`=1 after the second sample is lost.
  - Raising `period_ready` in the same cycle a new sample arrives keeps `period_valid`=1 with the new value.
- **Consecutive steps:** `trvl` high on 3 consecutive cycles, same direction. Required: two samples, each with `period`=1.
